ysyx_24100006_mem_wb: RTL

//  Pipeline stage directly downstream of the memory-access stage. Accepts finished

---
 rtl/ysyx_24100006_mem_wb_pkg.sv | 23 ++
 rtl/ysyx_24100006_skid_fifo2.sv | 72 +++++++
 rtl/ysyx_24100006_mem_wb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ysyx_24100006_mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: field widths and the packed layout
// of one buffered instruction entry.
package ysyx_24100006_mem_wb_pkg;

    localparam int XLEN     = 32;
    localparam int GPR_AW_P = 4;   // RV32E register file
    localparam int CSR_AW   = 12;

    // Field order fixes the 84-bit packing seen by the FIFO.
    typedef struct packed {
        logic                irq;
        logic                is_break;
        logic                gpr_we;
        logic [GPR_AW_P-1:0] gpr_waddr;
        logic [XLEN-1:0]     gpr_wdata;
        logic                csr_we;
        logic [CSR_AW-1:0]   csr_waddr;
        logic [XLEN-1:0]     csr_wdata;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ysyx_24100006_skid_fifo2.sv
// Two-entry skid FIFO.
//   push/din         : write din into the tail slot (caller guarantees not_full)
//   pop              : drop the head slot (caller guarantees head_valid)
//   not_full         : registered, so upstream ready has no combinational path
//   head_*/second_*  : both slots exposed, head is the older one
module ysyx_24100006_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             not_full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             second_valid,
    output logic [WIDTH-1:0] second_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [1:0]       cnt_q, cnt_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             not_full_q, not_full_d;

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        // Ready is computed from next occupancy and then flopped.
        not_full_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            not_full_q <= 1'b1;
        end else begin
            mem_q      <= mem_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            not_full_q <= not_full_d;
        end
    end

    assign not_full     = not_full_q;
    assign head_valid   = (cnt_q != 2'd0);
    assign second_valid = (cnt_q == 2'd2);
    assign head_data    = mem_q[rd_ptr_q];
    assign second_data  = mem_q[~rd_ptr_q];

endmodule

// File: rtl/ysyx_24100006_mem_wb.sv
// MEM/WB stage: buffers finished instructions in a 2-entry skid FIFO, retires
// the head to the GPR/CSR write ports when fetch accepts the retire handshake,
// exports both buffered GPR writes for forwarding, and freezes after ebreak.
//   in_*      : entry offered by the memory stage (valid/ready)
//   commit_*  : retire handshake with fetch (commit_valid is same-cycle)
//   gpr_*/csr_* : register-file / CSR-file write ports
//   fw0_*/fw1_* : older / younger buffered GPR write
//   halted, retire_cnt : status
module ysyx_24100006_mem_wb
    import ysyx_24100006_mem_wb_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int GPR_AW = GPR_AW_P
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_irq,
    input  logic              in_is_break,
    input  logic              in_gpr_we,
    input  logic [GPR_AW-1:0] in_gpr_waddr,
    input  logic [31:0]       in_gpr_wdata,
    input  logic              in_csr_we,
    input  logic [11:0]       in_csr_waddr,
    input  logic [31:0]       in_csr_wdata,
    input  logic              commit_ready,
    output logic              commit_valid,
    output logic              commit_irq,
    output logic              gpr_wen,
    output logic [GPR_AW-1:0] gpr_waddr,
    output logic [31:0]       gpr_wdata,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [31:0]       csr_wdata,
    output logic              fw0_valid,
    output logic [GPR_AW-1:0] fw0_addr,
    output logic [31:0]       fw0_data,
    output logic              fw1_valid,
    output logic [GPR_AW-1:0] fw1_addr,
    output logic [31:0]       fw1_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt
);

    entry_t               in_entry, head, second;
    logic [ENTRY_W-1:0]   head_raw, second_raw;
    logic                 fifo_nf, head_vld, second_vld, push;
    logic                 halted_q, halted_d;
    logic [CNT_W-1:0]     retire_cnt_q, retire_cnt_d;
    logic                 head_vis, second_vis;

    always_comb begin
        in_entry           = '0;
        in_entry.irq       = in_irq;
        in_entry.is_break  = in_is_break;
        in_entry.gpr_we    = in_gpr_we;
        in_entry.gpr_waddr = in_gpr_waddr;
        in_entry.gpr_wdata = in_gpr_wdata;
        in_entry.csr_we    = in_csr_we;
        in_entry.csr_waddr = in_csr_waddr;
        in_entry.csr_wdata = in_csr_wdata;
    end

    assign in_ready = fifo_nf & ~halted_q;
    assign push     = in_valid & in_ready;

    ysyx_24100006_skid_fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .din          (in_entry),
        .pop          (commit_valid),
        .not_full     (fifo_nf),
        .head_valid   (head_vld),
        .head_data    (head_raw),
        .second_valid (second_vld),
        .second_data  (second_raw)
    );

    assign head   = entry_t'(head_raw);
    assign second = entry_t'(second_raw);

    // Reset gates the visible outputs so nothing buffered leaks out while the
    // flops are being cleared.
    assign head_vis   = head_vld & ~reset;
    assign second_vis = second_vld & ~reset;

    assign commit_valid = head_vis & commit_ready & ~halted_q;
    assign commit_irq   = commit_valid & head.irq;

    assign gpr_wen   = commit_valid & head.gpr_we & (head.gpr_waddr != '0);
    assign gpr_waddr = head_vis ? head.gpr_waddr : '0;
    assign gpr_wdata = head_vis ? head.gpr_wdata : '0;
    assign csr_wen   = commit_valid & head.csr_we;
    assign csr_waddr = head_vis ? head.csr_waddr : '0;
    assign csr_wdata = head_vis ? head.csr_wdata : '0;

    assign fw0_valid = head_vis & head.gpr_we & (head.gpr_waddr != '0);
    assign fw0_addr  = head_vis ? head.gpr_waddr : '0;
    assign fw0_data  = head_vis ? head.gpr_wdata : '0;
    assign fw1_valid = second_vis & second.gpr_we & (second.gpr_waddr != '0);
    assign fw1_addr  = second_vis ? second.gpr_waddr : '0;
    assign fw1_data  = second_vis ? second.gpr_wdata : '0;

    always_comb begin
        halted_d     = halted_q | (commit_valid & head.is_break);
        retire_cnt_d = retire_cnt_q + (commit_valid ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            halted_q     <= halted_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign halted     = halted_q;
    assign retire_cnt = retire_cnt_q;

endmodule
